vit_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the Viterbi decoder datapath. It generates the enables for branch-metric computation (CE), survivor shift (S), add-compare-select (ACS), survivor memory (M) and traceback (T) from a Moore state machine. It extends the fixed single-run sequencer with configurable fill and memory latencies, a framed mode with automatic termination, an explicit flush with traceback drain, and a completion pulse. It sits between the top-level decoder enable and the CE/S/ACS/M/T stages.

---
 rtl/vit_pkg.sv | 54 +++++
 rtl/vit_seq_ctrl_if.sv | 24 ++
 rtl/vit_cycle_cnt.sv | 26 ++
 rtl/vit_seq_ctrl.sv | 88 ++++++++
 tb/tb_vit_seq_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vit_pkg.sv
// Shared types for the Viterbi sequencing controller: state encoding and
// per-state stage-enable vectors.
package vit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ACS   = 3'd2,
    S_RUN   = 3'd3,
    S_MEMD  = 3'd4,
    S_TB    = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } vit_state_e;

  typedef struct packed {
    logic ce;
    logic s;
    logic acs;
    logic m;
    logic t;
  } en_vec_t;

  // Bit order {ce, s, acs, m, t}
  localparam en_vec_t EN_OFF   = 5'b00000;
  localparam en_vec_t EN_FILL  = 5'b11000;
  localparam en_vec_t EN_ACS   = 5'b11100;
  localparam en_vec_t EN_RUN   = 5'b11110;
  localparam en_vec_t EN_MEMD  = 5'b11010;
  localparam en_vec_t EN_TB    = 5'b11011;
  localparam en_vec_t EN_DRAIN = 5'b00011;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic en_vec_t en_of(input vit_state_e s);
    case (s)
      S_FILL:  return EN_FILL;
      S_ACS:   return EN_ACS;
      S_RUN:   return EN_RUN;
      S_MEMD:  return EN_MEMD;
      S_TB:    return EN_TB;
      S_DRAIN: return EN_DRAIN;
      default: return EN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/vit_seq_ctrl_if.sv
// Control/status bundle between the decoder top level and the sequencer.
interface vit_seq_ctrl_if;
  logic       en;
  logic       i_sync;
  logic       i_flush;
  logic       o_en_ce;
  logic       o_en_s;
  logic       o_en_acs;
  logic       o_en_m;
  logic       o_en_t;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_state;

  modport master (
    output en, i_sync, i_flush,
    input  o_en_ce, o_en_s, o_en_acs, o_en_m, o_en_t, o_busy, o_done, o_state
  );

  modport slave (
    input  en, i_sync, i_flush,
    output o_en_ce, o_en_s, o_en_acs, o_en_m, o_en_t, o_busy, o_done, o_state
  );
endinterface

// File: rtl/vit_cycle_cnt.sv
// Loadable down-counter shared by all timed sequencer states; saturates at 0.
module vit_cycle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = value;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/vit_seq_ctrl.sv
// Moore sequencer producing CE/S/ACS/M/T stage enables for the Viterbi datapath,
// with configurable fill/memory latency, framed termination, flush and drain.
module vit_seq_ctrl
  import vit_pkg::*;
#(
  parameter int FILL_CYC  = 2,
  parameter int MEM_DELAY = 8,
  parameter int DRAIN_LEN = 16,
  parameter int FRAMED    = 0,
  parameter int FRAME_LEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  vit_seq_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(max4(FILL_CYC, MEM_DELAY, DRAIN_LEN, FRAME_LEN) + 1);

  vit_state_e       state_q, state_d;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  en_vec_t          en_v;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Every transition into a timed state reloads the shared counter with length-1.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_FILL;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(FILL_CYC - 1);
        end
        S_FILL:  if (cnt_zero) state_d = S_ACS;
        S_ACS:   state_d = S_RUN;
        S_RUN: begin
          if (bus.i_sync) begin
            state_d  = S_MEMD;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(MEM_DELAY - 1);
          end
        end
        S_MEMD: begin
          if (cnt_zero) begin
            state_d  = S_TB;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(FRAME_LEN - 1);
          end
        end
        S_TB: begin
          if (bus.i_flush || (FRAMED != 0 && cnt_zero)) begin
            state_d  = S_DRAIN;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(DRAIN_LEN - 1);
          end
        end
        S_DRAIN: if (cnt_zero) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  vit_cycle_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (bus.en),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  assign en_v         = en_of(state_q);
  assign bus.o_en_ce  = en_v.ce;
  assign bus.o_en_s   = en_v.s;
  assign bus.o_en_acs = en_v.acs;
  assign bus.o_en_m   = en_v.m;
  assign bus.o_en_t   = en_v.t;
  assign bus.o_busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.o_done   = (state_q == S_DONE);
  assign bus.o_state  = state_q;
endmodule

// File: tb/tb_vit_seq_ctrl.sv
// Bench for vit_seq_ctrl: a continuous (dut0) and a framed FRAME_LEN=4 (dut1)
// instance checked every cycle against a state/elapsed-cycle reference model.
module tb_vit_seq_ctrl;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  vit_seq_ctrl_if b0();
  vit_seq_ctrl_if b1();

  vit_seq_ctrl #(.FILL_CYC(2), .MEM_DELAY(8), .DRAIN_LEN(16), .FRAMED(0), .FRAME_LEN(64))
    dut0 (.clk(clk), .rst(rst0), .bus(b0));
  vit_seq_ctrl #(.FILL_CYC(2), .MEM_DELAY(8), .DRAIN_LEN(16), .FRAMED(1), .FRAME_LEN(4))
    dut1 (.clk(clk), .rst(rst1), .bus(b1));

  localparam int FILL = 2;
  localparam int MEMD = 8;
  localparam int DRN  = 16;
  int framed [2] = '{0, 1};
  int flen   [2] = '{64, 4};

  int checks = 0;
  int errors = 0;
  int ms [2];   // model state code
  int ma [2];   // enabled cycles already spent in the current state

  typedef struct {
    logic [3:0] in;   // {rst, en, sync, flush}
    int         exp;  // state code observed in the cycle these inputs are applied
  } vec_t;
  vec_t tv[$];

  // {state, ce, s, acs, m, t, busy, done} as the spec's state table dictates
  function automatic logic [9:0] expv(input int st);
    logic [2:0] s3;
    logic ce, acs, m, t, busy, done;
    s3   = 3'(st);
    ce   = (st >= 1 && st <= 5);
    acs  = (st == 2 || st == 3);
    m    = (st >= 3 && st <= 6);
    t    = (st == 5 || st == 6);
    busy = (st != 0 && st != 7);
    done = (st == 7);
    return {s3, ce, ce, acs, m, t, busy, done};
  endfunction

  function automatic logic [9:0] actv(input int i);
    if (i == 0)
      return {b0.o_state, b0.o_en_ce, b0.o_en_s, b0.o_en_acs, b0.o_en_m, b0.o_en_t,
              b0.o_busy, b0.o_done};
    return {b1.o_state, b1.o_en_ce, b1.o_en_s, b1.o_en_acs, b1.o_en_m, b1.o_en_t,
            b1.o_busy, b1.o_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_upd(input int i, input logic [3:0] a);
    int nx;
    nx = ms[i];
    if (a[3]) nx = 0;
    else if (a[2]) begin
      case (ms[i])
        0: nx = 1;
        1: if (ma[i] + 1 >= FILL) nx = 2;
        2: nx = 3;
        3: if (a[1]) nx = 4;
        4: if (ma[i] + 1 >= MEMD) nx = 5;
        5: if (a[0] || (framed[i] != 0 && ma[i] + 1 >= flen[i])) nx = 6;
        6: if (ma[i] + 1 >= DRN) nx = 7;
        default: nx = 0;
      endcase
    end
    if (a[3] || nx != ms[i]) ma[i] = 0;
    else if (a[2]) ma[i]++;
    ms[i] = nx;
  endtask

  // Called at a falling edge: check current outputs, apply inputs for the next rising edge.
  task automatic step(input logic [3:0] a0, input logic [3:0] a1);
    chk("model0", 32'(actv(0)), 32'(expv(ms[0])));
    chk("model1", 32'(actv(1)), 32'(expv(ms[1])));
    rst0 = a0[3]; b0.en = a0[2]; b0.i_sync = a0[1]; b0.i_flush = a0[0];
    rst1 = a1[3]; b1.en = a1[2]; b1.i_sync = a1[1]; b1.i_flush = a1[0];
    model_upd(0, a0);
    model_upd(1, a1);
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_in(input int rmod, input int emod, input int smod,
                                        input int fmod);
    logic r, e, s, f;
    r = (rmod > 0) && ($urandom_range(rmod - 1, 0) == 0);
    e = ($urandom_range(emod - 1, 0) != 0);
    s = ($urandom_range(smod - 1, 0) == 0);
    f = (fmod > 0) && ($urandom_range(fmod - 1, 0) == 0);
    return {r, e, s, f};
  endfunction

  task automatic add(input logic [3:0] in, input int exp, input int n);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    repeat (n) tv.push_back(v);
  endtask

  // Drive dut1 into S_TB and measure how long it stays; optional flush at t+3.
  task automatic run_framed(input bit fl);
    int n;
    logic f;
    step(4'b1100, 4'b1100);
    n = 0;
    while (b1.o_state != 3'd5 && n < 60) begin
      step(4'b1100, 4'b0110);
      n++;
    end
    chk("frame_reach", 32'(b1.o_state), 32'd5);
    n = 0;
    while (b1.o_state == 3'd5 && n < 20) begin
      f = fl && (n == 3);
      step(4'b1100, {3'b011, f});
      n++;
    end
    chk(fl ? "flush_dwell" : "frame_dwell", 32'(n), 32'd4);
    chk("frame_exit", 32'(b1.o_state), 32'd6);
  endtask

  initial begin
    int n, dn, ex;
    logic e;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.en = 1'b1; b0.i_sync = 1'b0; b0.i_flush = 1'b0;
    b1.en = 1'b1; b1.i_sync = 1'b0; b1.i_flush = 1'b0;
    ms[0] = 0; ms[1] = 0; ma[0] = 0; ma[1] = 0;
    @(negedge clk);

    // Directed default run: cycle 0 is the row after the two reset rows.
    add(4'b1100, 0, 2);  // reset, en high
    add(4'b0100, 0, 1);  // c0
    add(4'b0110, 1, 1);  // c1 FILL, sync ignored
    add(4'b0100, 1, 1);  // c2
    add(4'b0100, 2, 1);  // c3 ACS
    add(4'b0100, 3, 1);  // c4 RUN
    add(4'b0101, 3, 1);  // c5 flush ignored outside TB
    add(4'b0100, 3, 4);  // c6..c9
    add(4'b0110, 3, 1);  // c10 sync
    add(4'b0101, 4, 8);  // c11..c18 MEMD, flush ignored
    add(4'b0100, 5, 1);  // c19 TB
    foreach (tv[i]) begin
      chk("tbl", 32'(actv(0)), 32'(expv(tv[i].exp)));
      step(tv[i].in, tv[i].in);
    end

    // TB holds without flush; dut1 gets free random stimulus meanwhile.
    for (int i = 0; i < 200; i++)
      step({2'b01, 1'($urandom_range(1, 0)), 1'b0}, rnd_in(0, 6, 4, 6));
    chk("tb_hold", 32'(b0.o_state), 32'd5);
    step(4'b0101, rnd_in(0, 6, 4, 6));
    dn = 0;
    for (int j = 1; j <= 18; j++) begin
      ex = (j <= 16) ? 6 : ((j == 17) ? 7 : 0);
      chk("drain_seq", 32'(actv(0)), 32'(expv(ex)));
      if (b0.o_done) dn++;
      step(4'b0100, rnd_in(0, 6, 4, 6));
    end
    chk("done_pulses", 32'(dn), 32'd1);

    // Framed termination, then flush coinciding with frame expiry.
    run_framed(1'b0);
    run_framed(1'b1);

    // en stall of 5 cycles inside S_MEMD.
    step(4'b1100, 4'b1100);
    n = 0;
    while (b0.o_state != 3'd4 && n < 40) begin
      step(4'b0110, 4'b1100);
      n++;
    end
    chk("memd_reach", 32'(b0.o_state), 32'd4);
    n = 0;
    while (b0.o_state == 3'd4 && n < 40) begin
      e = !(n >= 3 && n < 8);
      if (n == 7) chk("stall_frozen", 32'(actv(0)), 32'(expv(4)));
      step({1'b0, e, 2'b00}, 4'b1100);
      n++;
    end
    chk("stall_memd", 32'(n), 32'd13);
    chk("stall_tb", 32'(b0.o_state), 32'd5);

    // Reset in the middle of the drain: no completion pulse afterwards.
    step(4'b0101, 4'b1100);
    repeat (5) step(4'b0100, 4'b1100);
    chk("drain_mid", 32'(b0.o_state), 32'd6);
    step(4'b1100, 4'b1100);
    chk("rst_drain", 32'(actv(0)), 32'(expv(0)));
    dn = 0;
    repeat (20) begin
      if (b0.o_done) dn++;
      step(4'b0000, 4'b0000);
    end
    chk("no_done", 32'(dn), 32'd0);
    chk("idle_hold", 32'(b0.o_state), 32'd0);

    // Free-running random stimulus on both instances.
    repeat (3000) step(rnd_in(64, 8, 5, 10), rnd_in(64, 8, 5, 10));
    step(4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
